// File: rtl/aurora_tx_pkt_sched.sv
`default_nettype none
// ============================================================================
// Module   : aurora_tx_pkt_sched
// Function : Frames FWFT ADC FIFO samples into header + payload packets for
//            the Aurora TX user interface, with link-health counters.
// Revision : 1.0 - initial release
// ============================================================================
module aurora_tx_pkt_sched #(
   parameter int          DATA_WD    = 128,
   parameter int          ADC_CNT_WD = 11,
   parameter int          HEAD_WD    = 64,
   parameter int          PKT_BEATS  = 256,
   parameter logic [15:0] HEAD_MAGIC = 16'h55AA
) (
   input  logic                  user_clk,
   input  logic                  cfg_rst,
   input  logic                  channel_up,
   input  logic                  adc_enable,
   output logic                  adc_fifo_rd,
   input  logic [DATA_WD-1:0]    adc_fifo_din,
   input  logic                  adc_fifo_empty,
   input  logic [ADC_CNT_WD-1:0] adc_fifo_data_cnt,
   output logic [DATA_WD-1:0]    m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [15:0]           pkt_sop_cnt,
   output logic [15:0]           pkt_eop_cnt,
   output logic [15:0]           pkt_abort_cnt,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HEAD = 2'd1,
      S_DATA = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   localparam logic [ADC_CNT_WD-1:0] c_PKT_CNT   = ADC_CNT_WD'(PKT_BEATS);
   localparam logic [ADC_CNT_WD-1:0] c_LAST_BEAT = ADC_CNT_WD'(PKT_BEATS - 1);
   localparam logic [15:0]           c_PKT_LEN   = 16'(PKT_BEATS);

   state_t                  r_state;
   logic [15:0]             r_seq;
   logic [ADC_CNT_WD-1:0]   r_beat_cnt;
   logic [15:0]             r_sop_cnt;
   logic [15:0]             r_eop_cnt;
   logic [15:0]             r_abort_cnt;

   logic                    w_start;
   logic                    w_data_vld;
   logic                    w_hs;
   logic                    w_last;
   logic [DATA_WD-1:0]      w_head;

   always_comb begin
      w_head                = '0;
      w_head[HEAD_WD-1:0]   = HEAD_WD'({HEAD_MAGIC, r_seq, c_PKT_LEN, 16'h0000});
   end

   assign w_start    = adc_enable & channel_up & (adc_fifo_data_cnt >= c_PKT_CNT);
   assign w_data_vld = (r_state == S_DATA) & ~adc_fifo_empty;
   assign w_last     = (r_beat_cnt == c_LAST_BEAT);
   assign w_hs       = m_axis_tvalid & m_axis_tready;

   // Payload is a straight pass-through of the FWFT head; pop only on handshake.
   assign m_axis_tvalid = (r_state == S_HEAD) | w_data_vld;
   assign m_axis_tlast  = (r_state == S_DATA) & w_last;
   assign m_axis_tdata  = (r_state == S_HEAD) ? w_head :
                          (r_state == S_DATA) ? adc_fifo_din : '0;
   assign adc_fifo_rd   = w_data_vld & m_axis_tready;

   assign busy          = (r_state != S_IDLE);
   assign pkt_sop_cnt   = r_sop_cnt;
   assign pkt_eop_cnt   = r_eop_cnt;
   assign pkt_abort_cnt = r_abort_cnt;

   always_ff @(posedge user_clk) begin
      if (cfg_rst) begin
         r_state     <= S_IDLE;
         r_seq       <= '0;
         r_beat_cnt  <= '0;
         r_sop_cnt   <= '0;
         r_eop_cnt   <= '0;
         r_abort_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) r_state <= S_HEAD;
            end
            S_HEAD: begin
               if (!channel_up) begin
                  r_state     <= S_IDLE;
                  r_abort_cnt <= r_abort_cnt + 16'd1;
                  r_seq       <= r_seq + 16'd1;
               end else if (w_hs) begin
                  r_state    <= S_DATA;
                  r_sop_cnt  <= r_sop_cnt + 16'd1;
                  r_beat_cnt <= '0;
               end
            end
            S_DATA: begin
               // Link loss takes priority over any beat completing this cycle.
               if (!channel_up) begin
                  r_state     <= S_IDLE;
                  r_abort_cnt <= r_abort_cnt + 16'd1;
                  r_seq       <= r_seq + 16'd1;
               end else if (w_hs) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  if (w_last) begin
                     r_state   <= S_GAP;
                     r_eop_cnt <= r_eop_cnt + 16'd1;
                     r_seq     <= r_seq + 16'd1;
                  end
               end
            end
            S_GAP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_pkt_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aurora_tx_pkt_sched
// Function : Directed self-checking bench for aurora_tx_pkt_sched (4-beat pkts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aurora_tx_pkt_sched;

   localparam int DW = 128;
   localparam int CW = 11;
   localparam int PB = 4;

   logic            user_clk = 1'b0;
   logic            cfg_rst;
   logic            channel_up;
   logic            adc_enable;
   logic            adc_fifo_rd;
   logic [DW-1:0]   adc_fifo_din;
   logic            adc_fifo_empty;
   logic [CW-1:0]   adc_fifo_data_cnt;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tlast;
   logic            m_axis_tready;
   logic [15:0]     pkt_sop_cnt;
   logic [15:0]     pkt_eop_cnt;
   logic [15:0]     pkt_abort_cnt;
   logic            busy;

   always #5 user_clk = ~user_clk;

   aurora_tx_pkt_sched #(
      .DATA_WD    (DW),
      .ADC_CNT_WD (CW),
      .HEAD_WD    (64),
      .PKT_BEATS  (PB),
      .HEAD_MAGIC (16'h55AA)
   ) u_dut (
      .user_clk          (user_clk),
      .cfg_rst           (cfg_rst),
      .channel_up        (channel_up),
      .adc_enable        (adc_enable),
      .adc_fifo_rd       (adc_fifo_rd),
      .adc_fifo_din      (adc_fifo_din),
      .adc_fifo_empty    (adc_fifo_empty),
      .adc_fifo_data_cnt (adc_fifo_data_cnt),
      .m_axis_tdata      (m_axis_tdata),
      .m_axis_tvalid     (m_axis_tvalid),
      .m_axis_tlast      (m_axis_tlast),
      .m_axis_tready     (m_axis_tready),
      .pkt_sop_cnt       (pkt_sop_cnt),
      .pkt_eop_cnt       (pkt_eop_cnt),
      .pkt_abort_cnt     (pkt_abort_cnt),
      .busy              (busy)
   );

   // FWFT FIFO model
   logic [DW-1:0] mem [0:63];
   int            wr_ptr  = 0;
   int            rd_ptr  = 0;
   int            pop_cnt = 0;

   assign adc_fifo_din      = mem[rd_ptr[5:0]];
   assign adc_fifo_empty    = (wr_ptr == rd_ptr);
   assign adc_fifo_data_cnt = CW'(wr_ptr - rd_ptr);

   always @(posedge user_clk) begin
      if (adc_fifo_rd) begin
         rd_ptr  <= rd_ptr + 1;
         pop_cnt <= pop_cnt + 1;
      end
   end

   int n_chk = 0;
   int n_err = 0;
   int exp_rd = 0;
   int exp_sop = 0;
   int exp_eop = 0;

   function automatic logic [DW-1:0] word(input int i);
      return {32'hBEEF_0000 + 32'(i), 32'(i * 7), 32'h5A5A_5A5A, 32'(i)};
   endfunction

   function automatic logic [DW-1:0] hdr(input logic [15:0] seq);
      return {64'h0, 16'h55AA, seq, 16'(PB), 16'h0000};
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr[5:0]] = word(wr_ptr);
         wr_ptr++;
      end
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!m_axis_tvalid && n < 20) begin
         tick();
         n++;
      end
      check(tag, m_axis_tvalid, 1'b1);
   endtask

   // Sends one full packet; toggle alternates tready, drop_en clears adc_enable mid-payload.
   task automatic send_pkt(input logic [15:0] seq, input bit toggle, input bit drop_en);
      int beat;
      int cyc;
      bit hs;
      wait_valid("hdr_wait");
      beat = -1;
      cyc  = 0;
      while (beat < PB && cyc < 40) begin
         m_axis_tready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (drop_en && beat == 1) adc_enable = 1'b0;
         #1;
         check("tvalid", m_axis_tvalid, 1'b1);
         if (beat < 0) begin
            check("hdr_data", m_axis_tdata, hdr(seq));
            check("hdr_last", m_axis_tlast, 1'b0);
            check("hdr_pop", adc_fifo_rd, 1'b0);
         end else begin
            check("pay_data", m_axis_tdata, word(exp_rd));
            check("pay_last", m_axis_tlast, beat == PB - 1);
            check("pay_pop", adc_fifo_rd, m_axis_tready);
         end
         hs = m_axis_tready;
         tick();
         if (hs) begin
            if (beat >= 0) exp_rd++;
            beat++;
         end
         cyc++;
      end
      m_axis_tready = 1'b1;
      exp_sop++;
      exp_eop++;
      check("gap_valid", m_axis_tvalid, 1'b0);
      check("gap_busy", busy, 1'b1);
      check("sop_cnt", pkt_sop_cnt, 16'(exp_sop));
      check("eop_cnt", pkt_eop_cnt, 16'(exp_eop));
      check("pop_total", pop_cnt, exp_rd);
      tick();
      check("idle_busy", busy, 1'b0);
   endtask

   initial begin
      cfg_rst       = 1'b1;
      channel_up    = 1'b1;
      adc_enable    = 1'b1;
      m_axis_tready = 1'b1;
      repeat (3) tick();
      cfg_rst = 1'b0;
      tick();
      check("rst_tvalid", m_axis_tvalid, 1'b0);
      check("rst_tlast", m_axis_tlast, 1'b0);
      check("rst_rd", adc_fifo_rd, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_sop", pkt_sop_cnt, 16'h0);
      check("rst_eop", pkt_eop_cnt, 16'h0);
      check("rst_abort", pkt_abort_cnt, 16'h0);

      // Basic packet
      push(4);
      send_pkt(16'd0, 1'b0, 1'b0);

      // Fill threshold
      push(3);
      repeat (4) tick();
      check("thr_tvalid", m_axis_tvalid, 1'b0);
      check("thr_busy", busy, 1'b0);
      check("thr_pops", pop_cnt, exp_rd);
      push(1);
      tick();
      check("thr_hdr_next", m_axis_tvalid, 1'b1);
      send_pkt(16'd1, 1'b0, 1'b0);

      // Backpressure
      push(4);
      send_pkt(16'd2, 1'b1, 1'b0);

      // Link loss after two payload beats
      push(4);
      wait_valid("abt_wait");
      check("abt_hdr", m_axis_tdata, hdr(16'd3));
      tick();
      exp_sop++;
      tick();
      tick();
      exp_rd += 2;
      channel_up    = 1'b0;
      m_axis_tready = 1'b0;
      tick();
      check("abt_tvalid", m_axis_tvalid, 1'b0);
      check("abt_busy", busy, 1'b0);
      check("abt_cnt", pkt_abort_cnt, 16'd1);
      check("abt_eop", pkt_eop_cnt, 16'(exp_eop));
      check("abt_pops", pop_cnt, exp_rd);
      channel_up    = 1'b1;
      m_axis_tready = 1'b1;
      push(2);
      send_pkt(16'd4, 1'b0, 1'b0);

      // adc_enable dropped mid-packet
      push(4);
      send_pkt(16'd5, 1'b0, 1'b1);
      push(4);
      repeat (5) tick();
      check("dis_tvalid", m_axis_tvalid, 1'b0);
      check("dis_busy", busy, 1'b0);
      check("dis_pops", pop_cnt, exp_rd);

      // Reset mid-payload
      adc_enable = 1'b1;
      wait_valid("rst_wait");
      check("pre_rst_hdr", m_axis_tdata, hdr(16'd6));
      tick();
      tick();
      exp_rd++;
      cfg_rst       = 1'b1;
      m_axis_tready = 1'b0;
      tick();
      check("mrst_tvalid", m_axis_tvalid, 1'b0);
      check("mrst_tlast", m_axis_tlast, 1'b0);
      check("mrst_tdata", m_axis_tdata, '0);
      check("mrst_rd", adc_fifo_rd, 1'b0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_sop", pkt_sop_cnt, 16'h0);
      check("mrst_eop", pkt_eop_cnt, 16'h0);
      check("mrst_abort", pkt_abort_cnt, 16'h0);
      check("mrst_pops", pop_cnt, exp_rd);
      cfg_rst       = 1'b0;
      m_axis_tready = 1'b1;
      exp_sop       = 0;
      exp_eop       = 0;
      push(1);
      tick();
      check("mrst_hdr_next", m_axis_tvalid, 1'b1);
      send_pkt(16'd0, 1'b0, 1'b0);
      check("mrst_abort_end", pkt_abort_cnt, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aurora_tx_pkt_sched.md
Name: aurora_tx_pkt_sched

Overview:
Packet scheduler between the ADC sample FIFO and the Aurora TX user interface, in the user_clk domain.
- When enough samples are buffered and the link is up, it emits one framed packet: a header beat followed by PKT_BEATS payload beats popped from the FIFO, with tlast on the final beat.
- It maintains sequence numbers and SOP/EOP/abort counters for link monitoring.

Parameters:
DATA_WD, 128, FIFO/AXIS data width (must be >= HEAD_WD)
ADC_CNT_WD, 11, width of FIFO fill count
HEAD_WD, 64, header field width, placed in the low bits of the header beat
PKT_BEATS, 256, payload beats per packet (1..2^ADC_CNT_WD-1)
HEAD_MAGIC, 16'h55AA, header sync word

Ports:
user_clk  in  1  Aurora user clock; all logic on its rising edge
cfg_rst  in  1  synchronous, active-high reset
channel_up  in  1  Aurora channel up
adc_enable  in  1  packet generation enable
adc_fifo_rd  out  1  FIFO pop (FWFT FIFO)
adc_fifo_din  in  DATA_WD  FIFO head word, valid while !adc_fifo_empty
adc_fifo_empty  in  1  FIFO empty
adc_fifo_data_cnt  in  ADC_CNT_WD  FIFO fill level
m_axis_tdata  out  DATA_WD  TX data to Aurora
m_axis_tvalid  out  1  TX valid
m_axis_tlast  out  1  last beat of packet
m_axis_tready  in  1  Aurora TX ready
pkt_sop_cnt  out  16  headers sent (wraps)
pkt_eop_cnt  out  16  tlast beats sent (wraps)
pkt_abort_cnt  out  16  packets aborted by link loss (wraps)
busy  out  1  high outside IDLE

Behaviour:
- Reset (cfg_rst=1 at a clock edge):
  - state=IDLE; seq=0; beat_cnt=0; all counters 0.
  - tvalid=0, tlast=0, adc_fifo_rd=0, busy=0.
  - Reset mid-packet drops the packet silently; no abort count.
- Transfer rule: a handshake is tvalid&tready on a clock edge. Once tvalid is asserted, tdata and tlast hold until the handshake, except on abort.
- FSM:
  - IDLE: move to HEAD when adc_enable & channel_up & (adc_fifo_data_cnt >= PKT_BEATS). The fill level is compared as unsigned ADC_CNT_WD.
  - HEAD:
    - tvalid=1, tlast=0.
    - tdata = zero-extended {HEAD_MAGIC[15:0], seq[15:0], PKT_BEATS[15:0], 16'h0}, with bit 63 the MSB of the magic. This is the HEAD_WD=64 layout.
    - On handshake: pkt_sop_cnt += 1, beat_cnt=0, go to DATA.
  - DATA:
    - tvalid = !adc_fifo_empty; tdata = adc_fifo_din (combinational pass-through from the FWFT head).
    - adc_fifo_rd = tvalid & tready, i.e. pop exactly on handshake.
    - tlast = (beat_cnt == PKT_BEATS-1).
    - On handshake: beat_cnt += 1.
    - On the tlast handshake: pkt_eop_cnt += 1, seq += 1 (wraps at 16 bits), go to GAP.
  - GAP: one idle cycle with tvalid=0, then go to IDLE. This guarantees at least one dead cycle between packets.
- Latency: start condition true at edge N gives the header tvalid at cycle N+1. The first payload beat is presented the cycle after the header handshake.
- Link loss: channel_up=0 while in HEAD or DATA gives, at the next edge:
  - state=IDLE, tvalid=0, pkt_abort_cnt += 1.
  - seq still increments.
  - FIFO words already popped are lost; no further pops.
- adc_enable deassert: ignored once in HEAD or DATA (the current packet completes). It only blocks new starts from IDLE.
- Empty FIFO in DATA should not occur because the start condition guarantees enough words. If it does, tvalid drops and the block stalls without popping or counting until data returns.
- adc_fifo_rd is never asserted outside DATA or while adc_fifo_empty=1.
- Counters are 16-bit wrapping: 16'hFFFF+1 = 0.
- busy is 1 in HEAD, DATA and GAP.

Test Plan:
1. PKT_BEATS=4, channel_up=1, adc_enable=1, data_cnt=4, tready=1 -> one header beat with tdata[63:0]=64'h55AA_0000_0004_0000, then 4 payload beats equal to FIFO words, tlast on the 4th beat only, 4 adc_fifo_rd pulses, sop=eop=1, then a GAP cycle.
2. data_cnt=3 with PKT_BEATS=4 -> stays IDLE, tvalid=0, no pops. Raise to 4 -> header appears the next cycle.
3. Toggle tready 1-0-1 every cycle during a packet -> tdata/tlast stable while stalled, pops only on handshake cycles, exactly 4 pops in total, second packet header carries seq=1.
4. Drop channel_up after 2 payload beats -> tvalid=0 the next cycle, pkt_abort_cnt=1, eop unchanged. Restore the link -> next header carries seq=1.
5. Deassert adc_enable during DATA -> packet completes with tlast. No new header while adc_enable=0 even if data_cnt >= 4.
6. Assert cfg_rst mid-DATA -> all outputs and counters 0 the next cycle, abort count stays 0, restart sends seq=0.
